// File: rtl/pipe_cla_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants and the bitwise generate/propagate helper
//               for the pipelined carry-lookahead adder.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Default lookahead block width; one pipeline stage per block.
    localparam int CLA_BLOCK_W = 8;

    // Per-bit generate/propagate pair.
    typedef struct packed {
        logic g;
        logic p;
    } claGp_t;

    // Generate is a&b, propagate is a^b (the xor form doubles as the
    // half-sum, so the block sum is simply p ^ carry).
    function automatic claGp_t claGenProp(input logic a, input logic b);
        claGp_t gp;
        gp.g = a & b;
        gp.p = a ^ b;
        return gp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_cla_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder_if
// Description : Operand / result handshake bundle for the pipelined CLA adder.
//               master = producer/consumer side, slave = adder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_cla_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = 4 * CLA_BLOCK_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, x, y, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/pipe_cla_adder_cla_block.sv
`default_nettype none
// ============================================================================
// Module      : cla_block
// Description : Combinational BLOCK_W-bit two-level carry-lookahead adder.
//               Every internal carry is a flat sum-of-products of g, p and
//               the block carry-in (no rippling inside the block).
// Revision    : 1.0 - initial release
// ============================================================================
module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK_W = CLA_BLOCK_W
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] sum,
    output logic               cout,
    output logic               cMsb
);

    logic [BLOCK_W-1:0] w_g;
    logic [BLOCK_W-1:0] w_p;
    logic [BLOCK_W:0]   w_c;

    for (genvar i = 0; i < BLOCK_W; i++) begin : g_gp
        claGp_t w_gp;
        assign w_gp   = claGenProp(a[i], b[i]);
        assign w_g[i] = w_gp.g;
        assign w_p[i] = w_gp.p;
    end

    // Carry into bit i+1 = cin&p[0..i] | OR_j ( g[j] & p[j+1..i] ).
    always_comb begin : p_carry
        logic w_term;
        logic w_prod;
        w_term = 1'b0;
        w_prod = 1'b0;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < BLOCK_W; i++) begin
            w_term = cin;
            for (int j = 0; j <= i; j++) begin
                w_term = w_term & w_p[j];
            end
            for (int j = 0; j <= i; j++) begin
                w_prod = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_prod = w_prod & w_p[k];
                end
                w_term = w_term | w_prod;
            end
            w_c[i+1] = w_term;
        end
    end

    assign sum  = w_p ^ w_c[BLOCK_W-1:0];
    assign cout = w_c[BLOCK_W];
    assign cMsb = w_c[BLOCK_W-1];

endmodule
`default_nettype wire

// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder
// Description : NSTG-stage pipelined carry-lookahead adder/subtractor with
//               valid/ready flow control and bubble-collapsing stages.
//               Stage k adds block k; upper operand bits ride along in skew
//               registers and finished sum bits accumulate in de-skew
//               registers so the last stage holds the complete result.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int BLOCK_W = CLA_BLOCK_W,
    parameter int NSTG    = WIDTH / BLOCK_W
) (
    input  logic            clk,
    input  logic            rst,
    pipe_cla_adder_if.slave bus
);

    logic [WIDTH-1:0] w_effB;
    logic             w_effCin;

    // Subtraction is x + ~y + 1; c_in only matters when adding.
    always_comb begin
        w_effB   = bus.sub ? ~bus.y : bus.y;
        w_effCin = bus.sub | bus.c_in;
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        localparam int  HI_W    = WIDTH - (k + 1) * BLOCK_W;
        localparam bit  IS_LAST = (k == NSTG - 1);

        logic                       r_valid;
        logic                       w_take;
        logic                       w_inValid;
        logic                       w_load;
        logic [BLOCK_W-1:0]         w_aBlk;
        logic [BLOCK_W-1:0]         w_bBlk;
        logic                       w_cinBlk;
        logic [BLOCK_W-1:0]         w_sumBlk;
        logic                       w_coutBlk;
        logic                       w_cMsbBlk;
        logic [(k+1)*BLOCK_W-1:0]   w_sumAll;

        // Block operands come from the ports for stage 0, otherwise from the
        // previous stage's skew registers and registered carry.
        if (k == 0) begin : g_src0
            assign w_inValid = bus.in_valid;
            assign w_aBlk    = bus.x[BLOCK_W-1:0];
            assign w_bBlk    = w_effB[BLOCK_W-1:0];
            assign w_cinBlk  = w_effCin;
            assign w_sumAll  = w_sumBlk;
        end else begin : g_srcN
            assign w_inValid = g_stage[k-1].r_valid;
            assign w_aBlk    = g_stage[k-1].g_hi.r_aHi[BLOCK_W-1:0];
            assign w_bBlk    = g_stage[k-1].g_hi.r_bHi[BLOCK_W-1:0];
            assign w_cinBlk  = g_stage[k-1].g_hi.r_carry;
            assign w_sumAll  = {w_sumBlk, g_stage[k-1].g_hi.r_sum};
        end

        // A stage can take new content when empty or when its content moves
        // on; the chain starts at out_ready so a full pipe keeps streaming.
        if (IS_LAST) begin : g_takeLast
            assign w_take = !r_valid || bus.out_ready;
        end else begin : g_takeMid
            assign w_take = !r_valid || g_stage[k+1].w_take;
        end

        // Data registers only load real operations, so bubbles never
        // disturb held values.
        assign w_load = w_take && w_inValid;

        cla_block #(
            .BLOCK_W (BLOCK_W)
        ) u_claBlock (
            .a    (w_aBlk),
            .b    (w_bBlk),
            .cin  (w_cinBlk),
            .sum  (w_sumBlk),
            .cout (w_coutBlk),
            .cMsb (w_cMsbBlk)
        );

        // Stage occupancy; reset discards everything in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
            end else if (w_take) begin
                r_valid <= w_inValid;
            end
        end

        if (!IS_LAST) begin : g_hi
            logic [HI_W-1:0]          r_aHi;
            logic [HI_W-1:0]          r_bHi;
            logic [(k+1)*BLOCK_W-1:0] r_sum;
            logic                     r_carry;
            logic [HI_W-1:0]          w_aRest;
            logic [HI_W-1:0]          w_bRest;

            if (k == 0) begin : g_rest0
                assign w_aRest = bus.x[WIDTH-1:BLOCK_W];
                assign w_bRest = w_effB[WIDTH-1:BLOCK_W];
            end else begin : g_restN
                assign w_aRest = g_stage[k-1].g_hi.r_aHi[HI_W+BLOCK_W-1:BLOCK_W];
                assign w_bRest = g_stage[k-1].g_hi.r_bHi[HI_W+BLOCK_W-1:BLOCK_W];
            end

            // Skew (unused operand bits), de-skew (finished sum bits) and
            // the carry into the next block.
            always_ff @(posedge clk) begin
                if (w_load) begin
                    r_aHi   <= w_aRest;
                    r_bHi   <= w_bRest;
                    r_sum   <= w_sumAll;
                    r_carry <= w_coutBlk;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] r_s;
            logic             r_cout;
            logic             r_ovf;
            logic             r_zero;

            // Result register; holds steady while the consumer stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s    <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_load) begin
                    r_s    <= w_sumAll;
                    r_cout <= w_coutBlk;
                    r_ovf  <= w_coutBlk ^ w_cMsbBlk;
                    r_zero <= (w_sumAll == '0);
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].w_take;
    assign bus.out_valid = g_stage[NSTG-1].r_valid;
    assign bus.s         = g_stage[NSTG-1].g_out.r_s;
    assign bus.c_out     = g_stage[NSTG-1].g_out.r_cout;
    assign bus.ovf       = g_stage[NSTG-1].g_out.r_ovf;
    assign bus.zero      = g_stage[NSTG-1].g_out.r_zero;

endmodule
`default_nettype wire

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a multiple of BLOCK_W and at least BLOCK_W.
REQ-002 Parameter BLOCK_W, default 8, lookahead block width; one pipeline stage per block.
REQ-003 Parameter NSTG, derived as WIDTH/BLOCK_W, pipeline depth; SHALL not be overridden.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  adder accepts operands this cycle.
REQ-008 x  input  WIDTH  operand A.
REQ-009 y  input  WIDTH  operand B.
REQ-010 c_in  input  1  carry-in for add mode; ignored when sub=1.
REQ-011 sub  input  1  mode select: 0 = x+y+c_in, 1 = x+~y+1.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result this cycle.
REQ-014 s  output  WIDTH  sum/difference.
REQ-015 c_out  output  1  unsigned carry-out (sub mode: 1 = no borrow).
REQ-016 ovf  output  1  signed two's-complement overflow.
REQ-017 zero  output  1  s equals all zeros.

Function
REQ-018 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 Stage k (0..NSTG-1) SHALL compute bits [k*BLOCK_W +: BLOCK_W] with full two-level lookahead (generate g=a&b, propagate p=a^b, every block carry a flat sum-of-products of g, p and block carry-in) plus the carry registered from stage k-1 (stage 0: effective carry-in).
REQ-020 Operand bits above the current stage SHALL travel in per-stage skew registers; computed sum bits SHALL travel in per-stage de-skew registers, so s emerges complete.
REQ-021 Effective B SHALL be y when sub=0, ~y when sub=1; effective carry-in SHALL be c_in when sub=0, 1 when sub=1.
REQ-022 Latency SHALL be exactly NSTG cycles from input transfer to out_valid with no backpressure; throughput one operation per cycle.
REQ-023 Each stage SHALL hold a valid bit; stage k SHALL advance when stage k+1 is empty or advancing; last stage advances when out_ready or empty (bubble-collapsing).
REQ-024 in_ready SHALL equal (stage 0 empty) || (stage 0 advancing); it SHALL be combinational from out_ready only through the advance chain.
REQ-025 A held result (out_valid && !out_ready) SHALL keep s, c_out, ovf, zero stable until transferred.
REQ-026 Results SHALL leave in input order; no operation lost or duplicated under any valid/ready pattern.
REQ-027 c_out SHALL be the carry out of bit WIDTH-1; ovf SHALL be (carry into MSB) XOR (carry out of MSB); zero SHALL be registered alongside s.
REQ-028 Simultaneous input and output transfer with the pipeline full SHALL be sustained without bubble.

Reset
REQ-029 rst SHALL clear all stage valid bits; out_valid=0, in_ready=1 on the cycle after rst deasserts.
REQ-030 s, c_out, ovf, zero SHALL reset to 0; datapath skew registers need not reset.
REQ-031 rst asserted mid-operation SHALL discard every in-flight operation; none SHALL appear afterwards.

Structure
REQ-032 Package cla_pkg SHALL hold BLOCK_W default and the carry-lookahead generate/propagate helper function.
REQ-033 One sub-module cla_block (BLOCK_W-bit combinational lookahead adder, outputs sum, block carry-out, carry into MSB) SHALL be instantiated NSTG times.

Verification (WIDTH=32, NSTG=4)
REQ-034 x=0xFFFFFFFF, y=0, c_in=1, sub=0 -> after 4 cycles s=0, c_out=1, zero=1, ovf=0.
REQ-035 x=5, y=7, sub=1 -> s=0xFFFFFFFE, c_out=0, ovf=0; x=7, y=5, sub=1 -> s=2, c_out=1.
REQ-036 x=0x7FFFFFFF, y=1, sub=0 -> s=0x80000000, ovf=1; x=0x80000000, y=1, sub=1 -> s=0x7FFFFFFF, ovf=1.
REQ-037 10 back-to-back ops, out_ready low cycles 3-6 -> in_ready drops once 4 held plus output held, all 10 results in order, none lost.
REQ-038 rst for one cycle with 3 ops in flight -> out_valid stays 0 until new input, then correct result after 4 cycles.
REQ-039 Random 10^5 ops with random valid/ready -> every result matches reference x+y+c_in / x-y model.
